// File: rtl/lvds_link_pkg.sv
// Shared definitions for the LVDS I/Q link: frame layout, sync markers and link states.
// Used by both the transmit framer and the receive deframer.
package lvds_link_pkg;

  localparam logic [1:0] SYNC_HI        = 2'b10;
  localparam logic [1:0] SYNC_LO        = 2'b01;
  localparam int         SAMPLE_W       = 13;
  localparam int         FRAME_W        = 32;
  localparam int         SYMS_PER_FRAME = 16;

  localparam logic [FRAME_W-1:0] EOM_FRAME  = 32'h8000_4000;
  localparam logic [FRAME_W-1:0] ZERO_FRAME = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    EOM  = 2'd3
  } link_state_e;

  // The marker bits after I and after Q are what the receiver locks onto.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [SAMPLE_W-1:0] i,
    input logic [SAMPLE_W-1:0] q
  );
    return {SYNC_HI, i, 1'b1, SYNC_LO, q, 1'b0};
  endfunction

endpackage

// File: rtl/lvds_frame_shifter.sv
// 32-bit frame serialiser: loads a frame every 16 clocks and shifts it out two bits per clock,
// MSB of each pair on tx_d[0]. The symbol counter free-runs so alignment survives every state.
module lvds_frame_shifter
  import lvds_link_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [FRAME_W-1:0] frame_in,
  output logic               boundary,
  output logic [1:0]         tx_d,
  output logic               frame_start
);

  localparam logic [3:0] LAST_SYM = 4'(SYMS_PER_FRAME - 1);

  logic [3:0]         sym_cnt_q, sym_cnt_d;
  logic [FRAME_W-1:0] sh_q, sh_d;
  logic [1:0]         tx_d_q, tx_d_d;
  logic               frame_start_q, frame_start_d;
  logic [FRAME_W-1:0] src_s;

  assign boundary    = (sym_cnt_q == LAST_SYM);
  assign tx_d        = tx_d_q;
  assign frame_start = frame_start_q;

  // Symbol 0 of a freshly loaded frame goes straight to the output register.
  always_comb begin
    if (boundary) begin
      src_s = frame_in;
    end else begin
      src_s = sh_q;
    end
    sym_cnt_d     = sym_cnt_q + 4'd1;
    tx_d_d        = {src_s[FRAME_W-2], src_s[FRAME_W-1]};
    sh_d          = {src_s[FRAME_W-3:0], 2'b00};
    frame_start_d = boundary;
  end

  // Shift/output registers; reset forces the line to zero at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sym_cnt_q     <= 4'd0;
      sh_q          <= ZERO_FRAME;
      tx_d_q        <= 2'b00;
      frame_start_q <= 1'b0;
    end else begin
      sym_cnt_q     <= sym_cnt_d;
      sh_q          <= sh_d;
      tx_d_q        <= tx_d_d;
      frame_start_q <= frame_start_d;
    end
  end

endmodule

// File: rtl/lvds_iq_framer.sv
// Transmit framer for the LVDS I/Q link: sequences idle, preamble, data and end-of-message
// frames on 16-symbol boundaries and hands them to the 2-bit serialiser.
module lvds_iq_framer
  import lvds_link_pkg::*;
#(
  parameter int PRE_FRAMES = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                s_valid,
  input  logic [SAMPLE_W-1:0] s_i,
  input  logic [SAMPLE_W-1:0] s_q,
  input  logic                s_last,
  output logic                s_ready,
  output logic [1:0]          tx_d,
  output logic                frame_start,
  output logic                busy,
  output logic                done,
  output logic [7:0]          underrun_cnt
);

  localparam logic [3:0] PRE_LAST = 4'(PRE_FRAMES - 1);

  link_state_e        state_q, state_d;
  logic [3:0]         pre_cnt_q, pre_cnt_d;
  logic               last_q, last_d;
  logic [7:0]         underrun_q, underrun_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [FRAME_W-1:0] frame_s;
  logic               boundary_s;
  logic               ready_s;

  lvds_frame_shifter u_shifter (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_in    (frame_s),
    .boundary    (boundary_s),
    .tx_d        (tx_d),
    .frame_start (frame_start)
  );

  assign s_ready      = ready_s;
  assign busy         = busy_q;
  assign done         = done_q;
  assign underrun_cnt = underrun_q;

  // Ready is decided from state and enable only, so the source may wait on it.
  always_comb begin
    ready_s = 1'b0;
    if (boundary_s) begin
      case (state_q)
        PRE:     ready_s = enable && (pre_cnt_q == PRE_LAST);
        DATA:    ready_s = enable && !last_q;
        default: ready_s = 1'b0;
      endcase
    end else begin
      ready_s = 1'b0;
    end
  end

  // Boundary decisions: next state and the frame that occupies the next 16 symbols.
  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    last_d     = last_q;
    underrun_d = underrun_q;
    done_d     = 1'b0;
    frame_s    = ZERO_FRAME;
    if (boundary_s) begin
      case (state_q)
        IDLE: begin
          if (enable && s_valid) begin
            state_d   = PRE;
            pre_cnt_d = 4'd0;
          end else begin
            state_d = IDLE;
          end
        end
        PRE: begin
          if (!enable) begin
            state_d = IDLE;
          end else if (pre_cnt_q != PRE_LAST) begin
            pre_cnt_d = pre_cnt_q + 4'd1;
          end else if (s_valid) begin
            state_d = DATA;
            frame_s = build_frame(s_i, s_q);
            last_d  = s_last;
          end else begin
            state_d = PRE;
          end
        end
        DATA: begin
          if (last_q || !enable) begin
            state_d = EOM;
            frame_s = EOM_FRAME;
          end else if (s_valid) begin
            frame_s = build_frame(s_i, s_q);
            last_d  = s_last;
          end else if (underrun_q != 8'hFF) begin
            underrun_d = underrun_q + 8'd1;
          end else begin
            underrun_d = underrun_q;
          end
        end
        EOM: begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d != IDLE);
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pre_cnt_q  <= 4'd0;
      last_q     <= 1'b0;
      underrun_q <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      last_q     <= last_d;
      underrun_q <= underrun_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_lvds_iq_framer.sv
// Scoreboard bench for lvds_iq_framer: a receive-side deframer model recovers frames from tx_d
// and checks them against samples pushed at each handshake, with timing derived from cycle counts.
module tb_lvds_iq_framer;

  localparam int PRE_FRAMES = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic [12:0] s_i = 13'd0;
  logic [12:0] s_q = 13'd0;
  logic        s_ready, frame_start, busy, done;
  logic [1:0]  tx_d;
  logic [7:0]  underrun_cnt;

  lvds_iq_framer #(.PRE_FRAMES(PRE_FRAMES)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .s_valid      (s_valid),
    .s_i          (s_i),
    .s_q          (s_q),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .tx_d         (tx_d),
    .frame_start  (frame_start),
    .busy         (busy),
    .done         (done),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          eom;
    logic [12:0] i;
    logic [12:0] q;
    int          start;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          prev_hs = -1;
  int          exp_under = 0;
  int          recovered = 0;
  int          ready_pulses = 0;
  int          exp_done = -1;
  int          nsym = -1;
  int          fstart = 0;
  logic [31:0] word = 32'd0;
  logic [31:0] last_data_word = 32'd0;

  // Posedges since the last reset release; the link's symbol index is cyc mod 16.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  function automatic void check(input string name, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic int next_boundary(input int c);
    return c + (15 - (c % 16));
  endfunction

  // Deframer model: classify a received word and match it against the scoreboard.
  function automatic void score_frame(input logic [31:0] w, input int fs);
    exp_t e;
    if (w != 32'd0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame", w, 0);
      end else begin
        e = exp_q.pop_front();
        check("frame_start_cycle", fs, e.start);
        if (e.eom) begin
          check("eom_word", w, 32'h8000_4000);
          exp_done = fs + 16;
        end else begin
          check("sync_bits", {w[31:30], w[16], w[15:14], w[0]}, 6'b101010);
          check("rx_i", w[29:17], e.i);
          check("rx_q", w[13:1], e.q);
          recovered++;
          last_data_word = w;
        end
      end
    end
  endfunction

  // Monitor: per-cycle alignment/handshake rules plus symbol reassembly.
  always @(negedge clk) begin
    if (!reset_n) begin
      nsym     = -1;
      exp_done = -1;
    end else begin
      check("frame_start_align", frame_start, (cyc % 16 == 0) && (cyc > 0));
      check("ready_off_boundary", s_ready && (cyc % 16 != 15), 0);
      check("done_timing", done, cyc == exp_done);
      if (cyc == exp_done) check("busy_after_done", busy, 0);
      if (s_ready) ready_pulses++;
      if (frame_start) begin
        nsym   = 0;
        fstart = cyc;
      end
      if (nsym >= 0) begin
        word = {word[29:0], tx_d[0], tx_d[1]};
        nsym++;
        if (nsym == 16) begin
          nsym = -1;
          score_frame(word, fstart);
        end
      end
    end
  end

  task automatic do_reset();
    s_valid = 1'b0;
    enable  = 1'b0;
    s_last  = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("reset_tx_d", tx_d, 0);
    check("reset_ready", s_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_frame_start", frame_start, 0);
    check("reset_underrun", underrun_cnt, 0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    prev_hs   = -1;
    exp_under = 0;
    #2 reset_n = 1'b1;
  endtask

  // Present one sample and wait (bounded) for its handshake; push the expected frame(s).
  task automatic send(input logic [12:0] i, input logic [12:0] q, input bit last,
                      input int gap, input bit first_s, output int hs);
    int raise;
    int exp_hs;
    hs = -1;
    repeat (gap) @(negedge clk);
    s_valid = 1'b1;
    s_i     = i;
    s_q     = q;
    s_last  = last;
    raise   = cyc;
    for (int w = 0; w < 400 && hs < 0; w++) begin
      if (s_ready) hs = cyc;
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (hs < 0) begin
      check("handshake_timeout", 0, 1);
    end else begin
      exp_hs = first_s ? next_boundary(raise) + 16 * PRE_FRAMES : next_boundary(raise);
      check("handshake_cycle", hs, exp_hs);
      if (!first_s && prev_hs >= 0) begin
        exp_under += (hs - prev_hs) / 16 - 1;
        if (exp_under > 255) exp_under = 255;
      end
      prev_hs = hs;
      exp_q.push_back('{eom: 1'b0, i: i, q: q, start: hs + 1});
      if (last) exp_q.push_back('{eom: 1'b1, i: 13'd0, q: 13'd0, start: hs + 17});
    end
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int w = 0; w < 200 && !seen; w++) begin
      @(negedge clk);
      seen = done;
    end
    check("done_seen", seen, 1);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    check("underrun_cnt", underrun_cnt, exp_under);
    enable  = 1'b0;
    prev_hs = -1;
  endtask

  task automatic message(input int n, input int maxgap, input int drop_after);
    int hs;
    int rec0;
    rec0   = recovered;
    enable = 1'b1;
    for (int k = 0; k < n; k++) begin
      send(13'($urandom), 13'($urandom), k == n - 1,
           (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0, k == 0, hs);
      if (k + 1 == drop_after) begin
        enable = 1'b0;
        exp_q.push_back('{eom: 1'b1, i: 13'd0, q: 13'd0, start: hs + 17});
        break;
      end
    end
    wait_idle();
    check("msg_recovered", recovered - rec0, (drop_after > 0) ? drop_after : n);
  endtask

  initial begin
    int hs;
    int r0;
    int rec0;
    int fs_cnt;

    // Idle after reset: silent line, no ready, frame_start every 16 cycles.
    do_reset();
    fs_cnt = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      check("idle_tx_d", tx_d, 0);
      check("idle_ready", s_ready, 0);
      if (frame_start) fs_cnt++;
    end
    check("idle_frame_starts", fs_cnt, 4);

    // Single known sample with s_last.
    enable = 1'b1;
    send(13'h1555, 13'h0AAA, 1'b1, 0, 1'b1, hs);
    check("first_symbol", tx_d, 2'b01);
    check("data_frame_start", frame_start, 1);
    check("busy_in_data", busy, 1);
    wait_idle();
    check("single_word", last_data_word, 32'hAAAB_5554);

    // Four back-to-back samples.
    r0 = ready_pulses;
    message(4, 0, 0);
    check("b2b_ready_pulses", ready_pulses - r0, 4);

    // Enable dropped after the 2nd of 5 samples.
    r0 = ready_pulses;
    message(5, 0, 2);
    check("drop_ready_pulses", ready_pulses - r0, 2);
    r0 = ready_pulses;
    s_valid = 1'b1;
    repeat (48) @(negedge clk);
    s_valid = 1'b0;
    check("no_ready_when_disabled", ready_pulses - r0, 0);

    // One missed DATA boundary gives exactly one fill frame.
    do_reset();
    enable = 1'b1;
    send(13'($urandom), 13'($urandom), 1'b0, 0, 1'b1, hs);
    send(13'($urandom), 13'($urandom), 1'b0, 20, 1'b0, hs);
    send(13'($urandom), 13'($urandom), 1'b1, 0, 1'b0, hs);
    wait_idle();
    check("underrun_one", underrun_cnt, 1);

    // 100 random samples over several messages with random gaps.
    for (int m = 0; m < 5; m++) message(20, 40, 0);

    // Async reset in the middle of a data frame, then resync.
    rec0   = recovered;
    enable = 1'b1;
    for (int k = 0; k < 6; k++) send(13'($urandom), 13'($urandom), 1'b0, 0, k == 0, hs);
    while (cyc % 16 != 7) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_tx_d", tx_d, 0);
    check("async_reset_busy", busy, 0);
    check("dropped_pending", exp_q.size(), 1);
    check("recovered_before_reset", recovered - rec0, 5);
    enable = 1'b0;
    exp_q.delete();
    prev_hs   = -1;
    exp_under = 0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    message(10, 30, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/lvds_iq_framer.md
# lvds_iq_framer

Transmit-side framer for the 32-bit LVDS I/Q link. Accepts 13-bit I/Q samples over a valid/ready handshake, builds sync-marked frames and emits them as 2-bit-per-clock symbols for the DDR output primitive. Its output format matches the DDR receive/deframer path bit-for-bit: 16 symbols per frame, all-zero frames for idle and resync, and an end-of-message frame. It sits between the sample source (`signal_gen` / CW override) and the DDR output register, on the 64 MHz domain.

## Interface
- `PRE_FRAMES`, 1: zero frames sent after leaving IDLE, before the first data frame (1..15).
- `clk`  in  1  symbol clock (64 MHz domain).
- `reset_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `enable`  in  1  level; request or continue a message.
- `s_valid`  in  1  sample available.
- `s_i`  in  13  I sample, two's complement.
- `s_q`  in  13  Q sample, two's complement.
- `s_last`  in  1  qualifies `s_valid`; marks the final sample of the message.
- `s_ready`  out  1  sample accepted when high together with `s_valid`.
- `tx_d`  out  2  symbol. `tx_d[0]` carries the earlier (more significant) bit of the pair.
- `frame_start`  out  1  high while symbol 0 of any frame is on `tx_d`.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse after the last EOM symbol.
- `underrun_cnt`  out  8  saturating count of fill frames inserted while in DATA.

## Operation
- Data frame: {2'b10, I[12:0], 1'b1, 2'b01, Q[12:0], 1'b0}.
- EOM frame: 32'h8000_4000. Zero frame: 32'h0.
- Symbol k (k = 0..15) of frame F is {`tx_d[1]`, `tx_d[0]`} = {F[30-2k], F[31-2k]}.
- `sym_cnt` (4 bit) free-runs 0..15 and wraps in every state, so frame alignment is never lost. The "boundary" is the cycle with `sym_cnt`==15.
- State machine. Each state changes only at a boundary, except on reset.
  - IDLE: send zero frames. At a boundary with `enable`=1 and `s_valid`=1, go to PRE and clear `pre_cnt`.
  - PRE: send zero frames and count them. At the boundary of frame `PRE_FRAMES`-1, assert `s_ready`.
    - If `s_valid`=1: load the sample and go to DATA.
    - If `s_valid`=0: stay in PRE and repeat the check at the next boundary.
  - DATA, at each boundary:
    - If the previously loaded sample had `s_last`, or `enable`=0: go to EOM. `s_ready` stays 0.
    - Else if `s_valid`=1: assert `s_ready` and load the next data frame.
    - Else: load a zero fill frame and increment `underrun_cnt` (saturates at 255).
  - EOM: send one EOM frame. At its boundary, pulse `done` and go to IDLE.
- `s_ready` is high only in boundary cycles, and combinationally never depends on `s_valid`.
- `enable` falling in PRE: go to IDLE at the next boundary with no EOM.
- `underrun_cnt` clears only on reset.

## Timing
- Handshake at cycle t (a boundary) puts symbol 0 of that sample's frame on `tx_d` at t+1. The last symbol appears at t+16.
- Back-to-back samples give contiguous frames with no gap. `s_ready` pulses every 16 cycles.
- `tx_d`, `frame_start`, `busy`, `done` and `underrun_cnt` are all registered.
- Reset values: `tx_d`=0, `s_ready`=0, `frame_start`=0, `busy`=0, `done`=0, `underrun_cnt`=0, state=IDLE, `sym_cnt`=0.
- Reset asserted mid-frame: `tx_d` goes to 0 immediately (asynchronously). The partial frame is dropped with no EOM.
- The first `frame_start` after reset release is at the cycle where `sym_cnt` wraps to 0.

## Structure
- Package `lvds_link_pkg` holds:
  - `SYNC_HI`=2'b10, `SYNC_LO`=2'b01, `SAMPLE_W`=13, `FRAME_W`=32, `SYMS_PER_FRAME`=16;
  - `EOM_FRAME`, the state enum (IDLE, PRE, DATA, EOM);
  - function `build_frame(i,q)`.
- The package is shared with the receive deframer.
- One sub-module, `lvds_frame_shifter`: a 32-bit load/shift-by-2 register with `sym_cnt`, producing `tx_d` and `frame_start`.

## Test plan
- Reset with `enable`=0 for 64 cycles: `tx_d`==0 and `s_ready`==0 throughout, and `frame_start` pulses every 16 cycles.
- Single sample I=13'h1555, Q=13'h0AAA, `s_last`=1, `PRE_FRAMES`=1: expect, in order,
  - one zero frame;
  - frame 32'hAAAB_5554, whose first symbol is `tx_d`=2'b01;
  - frame 32'h8000_4000;
  - a `done` pulse, then zeros with `busy`=0.
- Four samples with `s_valid` held high: exactly 4 `s_ready` pulses 16 cycles apart, with contiguous data frames and no zero gap.
- `s_valid` low at one DATA boundary: exactly one zero frame is inserted, `underrun_cnt`==1, and the following sample is sent intact.
- `enable` dropped after the 2nd of 5 samples: an EOM follows at the next boundary, `done` pulses, and no further `s_ready`.
- Loopback into the deframer model over 100 random samples, plus an async reset at `sym_cnt`==7: all samples before the reset are recovered, and the receiver resyncs after the post-reset zero frames.
